ifetch_align_buf: RTL and testbench

Instruction alignment buffer sitting directly upstream of the BJX2 instruction decoder.
- Accepts 64-bit, 8-byte-aligned fetch blocks from the fetch stage and queues them as 16-bit halfwords.
- Presents a 64-bit instruction window (istrWord) at the current 16-bit-aligned instruction boundary, with a length predecode.
- Maintains the jumbo-prefix history word (istrWordL) the decoder consumes.
- Retires one instruction per advance; flush on branch redirect.

---
 rtl/ifetch_align_buf.sv | 146 ++++++++++++++
 tb/tb_ifetch_align_buf.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_align_buf.sv
// Instruction alignment buffer: queues 64-bit fetch blocks as halfwords and
// presents a 64-bit window at the current instruction boundary to the decoder.
module ifetch_align_buf #(
  parameter int unsigned DEPTH_HW = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ifValid,
  output logic             ifReady,
  input  logic [63:0]      ifData,
  input  logic             flush,
  input  logic [1:0]       flushPcLo,
  output logic             idValid,
  input  logic             idAdvance,
  output logic [63:0]      istrWord,
  output logic [63:0]      istrWordL,
  output logic [1:0]       idLen,
  output logic             idJumbo,
  output logic             jumboOvf,
  output logic [CNT_W-1:0] bufCount
);

  localparam int unsigned PTR_W = $clog2(DEPTH_HW);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH_HW - 4);

  logic [15:0]      mem_q [DEPTH_HW];
  logic [15:0]      mem_d [DEPTH_HW];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       skip_q, skip_d, pcnt_q, pcnt_d;
  logic [63:0]      wordl_q, wordl_d;
  logic             ovf_q, ovf_d;

  logic [63:0] win_c;
  logic [15:0] hw0_c;
  logic [1:0]  len_c;
  logic        jumbo_c, valid_c, ready_c, accept_c, adv_c;

  // Window extraction and length predecode from registered state only
  always_comb begin
    win_c = '0;
    for (int k = 0; k < 4; k++) begin
      if (CNT_W'(k) < count_q) win_c[16*k +: 16] = mem_q[head_q + PTR_W'(k)];
    end
    hw0_c   = win_c[15:0];
    jumbo_c = (count_q != '0) && (hw0_c[15:8] == 8'hFE);
    if (count_q == '0)                  len_c = 2'd1;
    else if (jumbo_c)                   len_c = 2'd2;
    else if (hw0_c[15:13] != 3'b111)    len_c = 2'd1;
    else if (hw0_c[15:10] == 6'b111011 || hw0_c[15:10] == 6'b111111)
                                        len_c = 2'd3;
    else                                len_c = 2'd2;
    valid_c  = (count_q != '0) && (count_q >= CNT_W'(len_c));
    ready_c  = (count_q <= READY_MAX);
    accept_c = ifValid && ready_c && !flush;
    adv_c    = idAdvance && valid_c && !flush;
  end

  // Next-state: accept, retire, prefix history; flush overrides everything
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    skip_d  = skip_q;
    pcnt_d  = pcnt_q;
    wordl_d = wordl_q;
    ovf_d   = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      skip_d  = flushPcLo;
      pcnt_d  = '0;
      wordl_d = '0;
    end else begin
      if (accept_c) begin
        for (int i = 0; i < 4; i++) begin
          if (2'(i) >= skip_q)
            mem_d[tail_q + PTR_W'(i) - PTR_W'(skip_q)] = ifData[16*i +: 16];
        end
        tail_d = tail_q + PTR_W'(3'd4 - {1'b0, skip_q});
        skip_d = '0;
      end
      if (adv_c) begin
        head_d = head_q + PTR_W'(len_c);
        if (jumbo_c) begin
          case (pcnt_q)
            2'd0: begin
              wordl_d[31:0] = win_c[31:0];
              pcnt_d        = 2'd1;
            end
            2'd1: begin
              wordl_d[63:32] = win_c[31:0];
              pcnt_d         = 2'd2;
            end
            default: begin
              wordl_d = {32'h0, win_c[31:0]};
              pcnt_d  = 2'd1;
              ovf_d   = 1'b1;
            end
          endcase
        end else begin
          wordl_d = '0;
          pcnt_d  = '0;
        end
      end
      count_d = count_q
              + (accept_c ? CNT_W'(3'd4 - {1'b0, skip_q}) : '0)
              - (adv_c ? CNT_W'(len_c) : '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      skip_q  <= '0;
      pcnt_q  <= '0;
      wordl_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      skip_q  <= skip_d;
      pcnt_q  <= pcnt_d;
      wordl_q <= wordl_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ifReady   = ready_c;
  assign idValid   = valid_c;
  assign istrWord  = win_c;
  assign istrWordL = wordl_q;
  assign idLen     = len_c;
  assign idJumbo   = jumbo_c;
  assign jumboOvf  = ovf_q;
  assign bufCount  = count_q;

endmodule

// File: tb/tb_ifetch_align_buf.sv
// Bench for ifetch_align_buf: halfword-queue reference model, per-cycle compare,
// directed literal scenarios and randomized traffic with mid-stream resets.
module tb_ifetch_align_buf;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifValid, ifReady, flush, idValid, idAdvance, idJumbo, jumboOvf;
  logic [63:0] ifData, istrWord, istrWordL;
  logic [1:0]  flushPcLo, idLen;
  logic [4:0]  bufCount;

  ifetch_align_buf #(.DEPTH_HW(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .ifValid(ifValid), .ifReady(ifReady),
    .ifData(ifData), .flush(flush), .flushPcLo(flushPcLo), .idValid(idValid),
    .idAdvance(idAdvance), .istrWord(istrWord), .istrWordL(istrWordL),
    .idLen(idLen), .idJumbo(idJumbo), .jumboOvf(jumboOvf), .bufCount(bufCount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference model: a plain queue of buffered halfwords
  logic [15:0] mq[$];
  logic [1:0]  mskip, mpcnt;
  logic [63:0] mwl;
  logic        movf;

  function automatic int mlen();
    logic [15:0] h;
    if (mq.size() == 0) return 1;
    h = mq[0];
    if (h[15:8] == 8'hFE) return 2;
    if (h[15:13] != 3'b111) return 1;
    if (h[15:10] == 6'b111011 || h[15:10] == 6'b111111) return 3;
    return 2;
  endfunction

  function automatic logic mvalid();
    return (mq.size() >= 1) && (mq.size() >= mlen());
  endfunction

  function automatic logic mjumbo();
    return (mq.size() > 0) && (mq[0][15:8] == 8'hFE);
  endfunction

  function automatic logic [63:0] mword();
    logic [63:0] w = '0;
    for (int k = 0; k < 4; k++)
      if (k < mq.size()) w[16*k +: 16] = mq[k];
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    mskip = 2'd0;
    mpcnt = 2'd0;
    mwl   = '0;
    movf  = 1'b0;
  endtask

  task automatic model_step();
    int len;
    logic val, rdy, jmb;
    logic [63:0] w;
    len = mlen(); val = mvalid(); jmb = mjumbo(); w = mword();
    rdy = (DEPTH - mq.size()) >= 4;
    movf = 1'b0;
    if (flush) begin
      mq.delete();
      mpcnt = 2'd0;
      mwl   = '0;
      mskip = flushPcLo;
    end else begin
      if (idAdvance && val) begin
        if (jmb) begin
          if (mpcnt == 2'd0) begin mwl[31:0] = w[31:0]; mpcnt = 2'd1; end
          else if (mpcnt == 2'd1) begin mwl[63:32] = w[31:0]; mpcnt = 2'd2; end
          else begin movf = 1'b1; mwl = {32'h0, w[31:0]}; mpcnt = 2'd1; end
        end else begin
          mwl = '0;
          mpcnt = 2'd0;
        end
        repeat (len) void'(mq.pop_front());
      end
      if (ifValid && rdy) begin
        for (int i = int'(mskip); i < 4; i++) mq.push_back(ifData[16*i +: 16]);
        mskip = 2'd0;
      end
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      chk("ifReady",   64'(ifReady),   64'((DEPTH - mq.size()) >= 4));
      chk("idValid",   64'(idValid),   64'(mvalid()));
      chk("idLen",     64'(idLen),     64'(mlen()));
      chk("istrWord",  istrWord,       mword());
      chk("istrWordL", istrWordL,      mwl);
      chk("idJumbo",   64'(idJumbo),   64'(mjumbo()));
      chk("jumboOvf",  64'(jumboOvf),  64'(movf));
      chk("bufCount",  64'(bufCount),  64'(mq.size()));
    end
  end

  task automatic cyc(input logic v, input logic [63:0] d, input logic fl,
                     input logic [1:0] pc, input logic ad);
    ifValid = v; ifData = d; flush = fl; flushPcLo = pc; idAdvance = ad;
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_bufCount",  64'(bufCount), 64'd0);
    chk("rst_idValid",   64'(idValid),  64'd0);
    chk("rst_istrWord",  istrWord,      64'd0);
    chk("rst_istrWordL", istrWordL,     64'd0);
    chk("rst_ifReady",   64'(ifReady),  64'd1);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(0, 7))
      0, 1:    return {8'hFE, r[7:0]};
      2:       return {8'hFC, r[7:0]};
      3:       return {8'hF0, r[7:0]};
      4:       return {8'hEC, r[7:0]};
      default: return r;
    endcase
  endfunction

  localparam logic [63:0] ONES = 64'h0001_0001_0001_0001;

  initial begin
    reset = 1'b1;
    ifValid = 1'b0; ifData = '0; flush = 1'b0; flushPcLo = '0; idAdvance = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_count", 64'(bufCount), 64'd0);
    chk("reset_ready", 64'(ifReady), 64'd1);
    chk("reset_word",  istrWord, 64'd0);
    chk("reset_len",   64'(idLen), 64'd1);

    // 16-bit ops then drain
    cyc(1, 64'h0004_0003_0002_0001, 0, 0, 0);
    chk("blk_valid", 64'(idValid), 64'd1);
    chk("blk_len",   64'(idLen), 64'd1);
    chk("blk_word",  istrWord, 64'h0004_0003_0002_0001);
    for (int i = 3; i >= 0; i--) begin
      cyc(0, 0, 0, 0, 1);
      chk("drain_count", 64'(bufCount), 64'(i));
    end
    chk("drain_valid", 64'(idValid), 64'd0);

    // Flush with offset 2
    cyc(0, 0, 1, 2'd2, 0);
    cyc(1, 64'hDDDD_F123_BBBB_AAAA, 0, 0, 0);
    chk("skip_count", 64'(bufCount), 64'd2);
    chk("skip_word",  istrWord, 64'h0000_0000_DDDD_F123);
    chk("skip_len",   64'(idLen), 64'd2);
    cyc(0, 0, 0, 0, 1);
    chk("skip_empty", 64'(bufCount), 64'd0);

    // 48-bit op split across blocks
    cyc(1, 64'hFC00_3333_2222_1111, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1);
    chk("split_wait_valid", 64'(idValid), 64'd0);
    chk("split_wait_len",   64'(idLen), 64'd3);
    cyc(1, 64'h4444_5555_BBBB_AAAA, 0, 0, 0);
    chk("split_valid", 64'(idValid), 64'd1);
    chk("split_len",   64'(idLen), 64'd3);
    chk("split_word",  64'(istrWord[47:0]), 64'h0000_BBBB_AAAA_FC00);
    cyc(0, 0, 1, 0, 0);

    // Two prefixes then an op
    cyc(1, 64'h9ABC_FE78_3456_FE12, 0, 0, 0);
    cyc(1, 64'h0002_0001_1234_F000, 0, 0, 0);
    chk("pfx_jumbo", 64'(idJumbo), 64'd1);
    cyc(0, 0, 0, 0, 1);
    chk("pfx_wl1", istrWordL, 64'h0000_0000_3456_FE12);
    cyc(0, 0, 0, 0, 1);
    chk("pfx_wl2",   istrWordL, 64'h9ABC_FE78_3456_FE12);
    chk("pfx_opjmb", 64'(idJumbo), 64'd0);
    chk("pfx_oplen", 64'(idLen), 64'd2);
    cyc(0, 0, 0, 0, 1);
    chk("pfx_clear", istrWordL, 64'd0);
    cyc(0, 0, 1, 0, 0);

    // Three prefixes: overflow pulse
    cyc(1, 64'h2222_FE22_1111_FE11, 0, 0, 0);
    cyc(1, 64'h1234_F000_3333_FE33, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 1);
    chk("ovf_before", 64'(jumboOvf), 64'd0);
    cyc(0, 0, 0, 0, 1);
    chk("ovf_pulse", 64'(jumboOvf), 64'd1);
    chk("ovf_wl",    istrWordL, 64'h0000_0000_3333_FE33);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_end", 64'(jumboOvf), 64'd0);
    cyc(0, 0, 1, 0, 0);

    // Fill to capacity
    repeat (3) cyc(1, ONES, 0, 0, 0);
    chk("fill12_ready", 64'(ifReady), 64'd1);
    cyc(1, ONES, 0, 0, 0);
    chk("fill16_count", 64'(bufCount), 64'd16);
    chk("fill16_ready", 64'(ifReady), 64'd0);
    cyc(1, ONES, 0, 0, 1);
    chk("fill15_count", 64'(bufCount), 64'd15);
    chk("fill15_ready", 64'(ifReady), 64'd0);
    cyc(1, ONES, 0, 0, 1);
    cyc(1, ONES, 0, 0, 1);
    chk("fill13_ready", 64'(ifReady), 64'd0);
    cyc(0, ONES, 0, 0, 1);
    chk("fill12_count", 64'(bufCount), 64'd12);
    chk("fill12b_ready", 64'(ifReady), 64'd1);

    // Simultaneous accept, advance and flush
    cyc(0, 0, 1, 0, 0);
    cyc(1, 64'h9ABC_FE78_3456_FE12, 0, 0, 0);
    cyc(1, ONES, 0, 0, 1);
    chk("sim_pre_wl", istrWordL, 64'h0000_0000_3456_FE12);
    cyc(1, ONES, 1, 0, 1);
    chk("sim_count", 64'(bufCount), 64'd0);
    chk("sim_valid", 64'(idValid), 64'd0);
    chk("sim_wl",    istrWordL, 64'd0);

    // Mid-stream reset
    cyc(1, 64'h9ABC_FE78_3456_FE12, 0, 0, 0);
    cyc(1, ONES, 0, 0, 1);
    mid_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] d;
      d = {rand_hw(), rand_hw(), rand_hw(), rand_hw()};
      if (n % 700 == 350) begin
        mid_reset();
      end else begin
        cyc(logic'($urandom_range(0, 3) != 0), d, logic'($urandom_range(0, 31) == 0),
            2'($urandom_range(0, 3)), logic'($urandom_range(0, 9) < 6));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
